// File: rtl/win_pkg.sv
// Shared definitions for the windowed register-file spill/fill sequencer:
// controller states, window stride and window-op encodings.
package win_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SPILL  = 2'd1,
        S_FILL   = 2'd2,
        S_COMMIT = 2'd3
    } win_state_e;

    localparam int unsigned WIN_STRIDE = 4;

    localparam logic [1:0] WIN_ADV  = 2'b10;
    localparam logic [1:0] WIN_RET  = 2'b01;
    localparam logic [1:0] WIN_HOLD = 2'b00;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/win_spill_ctrl_frame_xfer.sv
// frame_xfer: walks one 4-word frame over a req/ack memory port.
// Request is held while a word is outstanding; the word index advances
// on the edge that accepts the ack; done marks the ack of the last word.
module frame_xfer
    import win_pkg::*;
(
    input  logic       clock,
    input  logic       reset_L,
    input  logic       start,
    input  logic       mem_ack,
    output logic       active,
    output logic       mem_req,
    output logic       word_ack,
    output logic       done,
    output logic [1:0] k
);

    localparam logic [1:0] LAST_K = 2'(WIN_STRIDE - 1);

    logic       active_q, active_d;
    logic [1:0] k_q, k_d;

    assign word_ack = active_q & mem_ack;
    assign done     = word_ack & (k_q == LAST_K);
    assign active   = active_q;
    assign mem_req  = active_q;
    assign k        = k_q;

    // Next word index / busy flag
    always_comb begin
        active_d = active_q;
        k_d      = k_q;
        if (start) begin
            active_d = 1'b1;
            k_d      = 2'd0;
        end else if (word_ack) begin
            k_d = k_q + 2'd1;
            if (k_q == LAST_K) begin
                active_d = 1'b0;
            end
        end
    end

    // Sequencer state; reset abandons any word in flight
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            active_q <= 1'b0;
            k_q      <= 2'd0;
        end else begin
            active_q <= active_d;
            k_q      <= k_d;
        end
    end

endmodule

// File: rtl/win_spill_ctrl.sv
// win_spill_ctrl: window sequencer for a 32-entry windowed register file
// (8 visible, stride 4). Moves the window on call/return, spilling the
// oldest frame to a memory stack on overflow and refilling it on underflow,
// stalling the CPU meanwhile.
// Optional build macro WINCTRL_STATS_EN adds saturating spill/fill counters.
module win_spill_ctrl
    import win_pkg::*;
#(
    parameter int unsigned NFRAMES    = 8,
    parameter logic [15:0] SPILL_BASE = 16'hF000
) (
    input  logic        clock,
    input  logic        reset_L,
    input  logic        win_push,
    input  logic        win_pop,
    output logic        stall,
    output logic [1:0]  win_op,
    output logic [4:0]  xfer_sel,
    output logic        xfer_we_L,
    output logic [15:0] xfer_wdata,
    input  logic [15:0] xfer_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
`ifdef WINCTRL_STATS_EN
    ,
    output logic [15:0] spill_cnt,
    output logic [15:0] fill_cnt
`endif
);

    localparam int unsigned FW      = $clog2(NFRAMES);
    localparam logic [FW-1:0] RES_MAX = FW'(NFRAMES - 2);
    localparam logic [15:0] STRIDE16 = 16'(WIN_STRIDE);

    win_state_e    state_q, state_d;
    logic [FW-1:0] cwp_q, cwp_d;
    logic [FW-1:0] res_q, res_d;
    logic [15:0]   sp_q, sp_d;
    logic [1:0]    win_op_q, win_op_d;
    logic          err_q, err_d;

    logic          xfer_start, xfer_active, xfer_word_ack, xfer_done;
    logic [1:0]    xfer_k;
    logic [FW-1:0] xfer_frame;
    logic [15:0]   xfer_base;

    frame_xfer u_xfer (
        .clock    (clock),
        .reset_L  (reset_L),
        .start    (xfer_start),
        .mem_ack  (mem_ack),
        .active   (xfer_active),
        .mem_req  (mem_req),
        .word_ack (xfer_word_ack),
        .done     (xfer_done),
        .k        (xfer_k)
    );

    // Spill takes the oldest live frame from the stack top; fill restores
    // the frame just below the current window from the last pushed slot.
    assign xfer_frame = (state_q == S_FILL) ? (cwp_q - 1'b1) : (cwp_q - res_q);
    assign xfer_base  = (state_q == S_FILL) ? (sp_q - STRIDE16) : sp_q;

    assign stall      = (state_q != S_IDLE);
    assign win_op     = win_op_q;
    assign err        = err_q;
    assign xfer_sel   = xfer_active ? 5'({xfer_frame, xfer_k}) : 5'd0;
    assign mem_addr   = xfer_active ? (xfer_base + {14'd0, xfer_k}) : 16'd0;
    assign mem_we     = (state_q == S_SPILL);
    assign mem_wdata  = (state_q == S_SPILL) ? xfer_rdata : 16'd0;
    assign xfer_wdata = (state_q == S_FILL) ? mem_rdata : 16'd0;
    assign xfer_we_L  = ~((state_q == S_FILL) & xfer_word_ack);

    // Next-state, window bookkeeping and strobed outputs
    always_comb begin
        state_d    = state_q;
        cwp_d      = cwp_q;
        res_d      = res_q;
        sp_d       = sp_q;
        win_op_d   = WIN_HOLD;
        err_d      = 1'b0;
        xfer_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_push && win_pop) begin
                    err_d = 1'b1;
                end else if (win_push) begin
                    if (res_q == RES_MAX) begin
                        state_d    = S_SPILL;
                        xfer_start = 1'b1;
                    end else begin
                        win_op_d = WIN_ADV;
                        res_d    = res_q + 1'b1;
                        cwp_d    = cwp_q + 1'b1;
                    end
                end else if (win_pop) begin
                    if (res_q != '0) begin
                        win_op_d = WIN_RET;
                        res_d    = res_q - 1'b1;
                        cwp_d    = cwp_q - 1'b1;
                    end else if (sp_q > SPILL_BASE) begin
                        state_d    = S_FILL;
                        xfer_start = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            // The deferred push/pop is applied on entry to COMMIT so the
            // window op is presented during the COMMIT cycle itself.
            // Resident count: -1 for the spill and +1 for the push cancel.
            S_SPILL: begin
                if (xfer_done) begin
                    state_d  = S_COMMIT;
                    sp_d     = sp_q + STRIDE16;
                    cwp_d    = cwp_q + 1'b1;
                    win_op_d = WIN_ADV;
                end
            end
            // Resident count: +1 for the fill and -1 for the pop cancel.
            S_FILL: begin
                if (xfer_done) begin
                    state_d  = S_COMMIT;
                    sp_d     = sp_q - STRIDE16;
                    cwp_d    = cwp_q - 1'b1;
                    win_op_d = WIN_RET;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Controller registers; reset mid-transfer discards it without commit
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= S_IDLE;
            cwp_q    <= '0;
            res_q    <= '0;
            sp_q     <= SPILL_BASE;
            win_op_q <= WIN_HOLD;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cwp_q    <= cwp_d;
            res_q    <= res_d;
            sp_q     <= sp_d;
            win_op_q <= win_op_d;
            err_q    <= err_d;
        end
    end

`ifdef WINCTRL_STATS_EN
    logic [15:0] spill_cnt_q, fill_cnt_q;

    assign spill_cnt = spill_cnt_q;
    assign fill_cnt  = fill_cnt_q;

    // Count completed frame transfers, saturating at all-ones
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            spill_cnt_q <= 16'd0;
            fill_cnt_q  <= 16'd0;
        end else if (xfer_done) begin
            if (state_q == S_SPILL) begin
                spill_cnt_q <= sat_inc16(spill_cnt_q);
            end else begin
                fill_cnt_q <= sat_inc16(fill_cnt_q);
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_win_spill_ctrl.sv
// Directed self-checking bench for win_spill_ctrl.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_win_spill_ctrl;

    logic        clock;
    logic        reset_L;
    logic        win_push, win_pop;
    logic        stall;
    logic [1:0]  win_op;
    logic [4:0]  xfer_sel;
    logic        xfer_we_L;
    logic [15:0] xfer_wdata, xfer_rdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        err;
`ifdef WINCTRL_STATS_EN
    logic [15:0] spill_cnt, fill_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int wr_total = 0;

    win_spill_ctrl dut (
        .clock      (clock),
        .reset_L    (reset_L),
        .win_push   (win_push),
        .win_pop    (win_pop),
        .stall      (stall),
        .win_op     (win_op),
        .xfer_sel   (xfer_sel),
        .xfer_we_L  (xfer_we_L),
        .xfer_wdata (xfer_wdata),
        .xfer_rdata (xfer_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .err        (err)
`ifdef WINCTRL_STATS_EN
        ,
        .spill_cnt  (spill_cnt),
        .fill_cnt   (fill_cnt)
`endif
    );

    // Register file model: phys reg i holds 16'h1100 + i.
    assign xfer_rdata = 16'h1100 + {11'd0, xfer_sel};
    // Memory model: word at address A reads as {4'hD, A[11:0]}.
    assign mem_rdata  = {4'hD, mem_addr[11:0]};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count accepted memory writes
    always @(posedge clock) begin
        if (mem_req && mem_ack && mem_we) wr_total <= wr_total + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset();
        win_push = 1'b0;
        win_pop  = 1'b0;
        mem_ack  = 1'b0;
        reset_L  = 1'b0;
        repeat (2) @(negedge clock);
        reset_L = 1'b1;
        @(negedge clock);
    endtask

    task automatic pulse_push();
        win_push = 1'b1;
        @(negedge clock);
        win_push = 1'b0;
    endtask

    task automatic pulse_pop();
        win_pop = 1'b1;
        @(negedge clock);
        win_pop = 1'b0;
    endtask

    // Waits (bounded) until stall is low.
    task automatic wait_idle(input string name);
        int n = 0;
        while (stall === 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_wait_idle: stall=%b required 0 within 50 cycles", name, stall);
        end
    endtask

    task automatic test_reset();
        win_push = 1'b0;
        win_pop  = 1'b0;
        mem_ack  = 1'b0;
        reset_L  = 1'b0;
        @(negedge clock);
        checks++;
        if ({stall, win_op, xfer_we_L, mem_req, mem_we, err} !== 7'b0_00_1_0_0_0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0001000",
                     {stall, win_op, xfer_we_L, mem_req, mem_we, err});
        end
        checks++;
        if (mem_addr !== 16'h0000 || dut.sp_q !== 16'hF000) begin
            errors++;
            $display("FAIL reset_addr_sp: mem_addr=%h sp=%h required 0000/F000", mem_addr, dut.sp_q);
        end
        reset_L = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_push3();
        do_reset();
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse_push();
            checks++;
            if (win_op !== 2'b10 || stall !== 1'b0) begin
                errors++;
                $display("FAIL push3_op%0d: win_op=%b stall=%b required 10/0", i, win_op, stall);
            end
        end
        @(negedge clock);
        checks++;
        if (win_op !== 2'b00 || stall !== 1'b0 || dut.res_q !== 3'd3) begin
            errors++;
            $display("FAIL push3_after: win_op=%b stall=%b resident=%0d required 00/0/3",
                     win_op, stall, dut.res_q);
        end
    endtask

    task automatic test_spill();
        int wr0;
        do_reset();
        mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) pulse_push();
        wr0 = wr_total;
        pulse_push();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({stall, mem_req, mem_we} !== 3'b111 || mem_addr !== 16'hF000 + 16'(k)
                || xfer_sel !== 5'(k) || mem_wdata !== 16'h1100 + 16'(k)) begin
                errors++;
                $display("FAIL spill_word%0d: st/req/we=%b addr=%h sel=%0d wdata=%h required 111/%h/%0d/%h",
                         k, {stall, mem_req, mem_we}, mem_addr, xfer_sel, mem_wdata,
                         16'hF000 + 16'(k), k, 16'h1100 + 16'(k));
            end
            @(negedge clock);
        end
        checks++;
        if (stall !== 1'b1 || win_op !== 2'b10 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL spill_commit: stall=%b win_op=%b req=%b required 1/10/0", stall, win_op, mem_req);
        end
        @(negedge clock);
        checks++;
        if (stall !== 1'b0 || win_op !== 2'b00 || dut.sp_q !== 16'hF004 || wr_total - wr0 != 4) begin
            errors++;
            $display("FAIL spill_done: stall=%b win_op=%b sp=%h writes=%0d required 0/00/F004/4",
                     stall, win_op, dut.sp_q, wr_total - wr0);
        end
`ifdef WINCTRL_STATS_EN
        checks++;
        if (spill_cnt !== 16'd1 || fill_cnt !== 16'd0) begin
            errors++;
            $display("FAIL spill_stats: spill_cnt=%0d fill_cnt=%0d required 1/0", spill_cnt, fill_cnt);
        end
`endif
    endtask

    task automatic test_spill_slow_ack();
        int wr0;
        do_reset();
        for (int i = 0; i < 6; i++) pulse_push();
        wr0 = wr_total;
        pulse_push();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'hF000 + 16'(k)) begin
                    errors++;
                    $display("FAIL slow_word%0d_cyc%0d: req=%b we=%b addr=%h required 1/1/%h",
                             k, i, mem_req, mem_we, mem_addr, 16'hF000 + 16'(k));
                end
                mem_ack = (i == 3);
                @(negedge clock);
            end
        end
        mem_ack = 1'b0;
        checks++;
        if (win_op !== 2'b10 || stall !== 1'b1 || wr_total - wr0 != 4) begin
            errors++;
            $display("FAIL slow_commit: win_op=%b stall=%b writes=%0d required 10/1/4",
                     win_op, stall, wr_total - wr0);
        end
        @(negedge clock);
    endtask

    task automatic test_fill();
        do_reset();
        mem_ack = 1'b1;
        for (int i = 0; i < 7; i++) pulse_push();
        wait_idle("fill_prep");
        for (int i = 0; i < 6; i++) begin
            pulse_pop();
            checks++;
            if (win_op !== 2'b01 || stall !== 1'b0) begin
                errors++;
                $display("FAIL fill_pop%0d: win_op=%b stall=%b required 01/0", i, win_op, stall);
            end
        end
        pulse_pop();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({stall, mem_req, mem_we, xfer_we_L} !== 4'b1100 || mem_addr !== 16'hF000 + 16'(k)
                || xfer_sel !== 5'(k) || xfer_wdata !== 16'hD000 + 16'(k)) begin
                errors++;
                $display("FAIL fill_word%0d: st/req/we/weL=%b addr=%h sel=%0d wdata=%h required 1100/%h/%0d/%h",
                         k, {stall, mem_req, mem_we, xfer_we_L}, mem_addr, xfer_sel, xfer_wdata,
                         16'hF000 + 16'(k), k, 16'hD000 + 16'(k));
            end
            @(negedge clock);
        end
        checks++;
        if (stall !== 1'b1 || win_op !== 2'b01 || xfer_we_L !== 1'b1) begin
            errors++;
            $display("FAIL fill_commit: stall=%b win_op=%b we_L=%b required 1/01/1", stall, win_op, xfer_we_L);
        end
        @(negedge clock);
        checks++;
        if (stall !== 1'b0 || dut.sp_q !== 16'hF000) begin
            errors++;
            $display("FAIL fill_done: stall=%b sp=%h required 0/F000", stall, dut.sp_q);
        end
        // Stack is empty again, so another return is illegal.
        pulse_pop();
        checks++;
        if (err !== 1'b1 || stall !== 1'b0 || win_op !== 2'b00) begin
            errors++;
            $display("FAIL fill_then_pop: err=%b stall=%b win_op=%b required 1/0/00", err, stall, win_op);
        end
    endtask

    task automatic test_errors();
        do_reset();
        pulse_pop();
        checks++;
        if (err !== 1'b1 || win_op !== 2'b00 || stall !== 1'b0) begin
            errors++;
            $display("FAIL err_pop_empty: err=%b win_op=%b stall=%b required 1/00/0", err, win_op, stall);
        end
        @(negedge clock);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_width: err=%b required 0", err);
        end
        pulse_push();
        win_push = 1'b1;
        win_pop  = 1'b1;
        @(negedge clock);
        win_push = 1'b0;
        win_pop  = 1'b0;
        checks++;
        if (err !== 1'b1 || win_op !== 2'b00 || dut.res_q !== 3'd1 || dut.cwp_q !== 3'd1) begin
            errors++;
            $display("FAIL err_push_pop: err=%b win_op=%b resident=%0d cwp=%0d required 1/00/1/1",
                     err, win_op, dut.res_q, dut.cwp_q);
        end
    endtask

    task automatic test_reset_mid_spill();
        do_reset();
        mem_ack = 1'b1;
        for (int i = 0; i < 7; i++) pulse_push();
        repeat (2) @(negedge clock);
        checks++;
        if (mem_addr !== 16'hF002 || stall !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: addr=%h stall=%b required F002/1", mem_addr, stall);
        end
        reset_L = 1'b0;
        #1;
        checks++;
        if ({stall, win_op, xfer_we_L, mem_req, mem_we, err} !== 7'b0_00_1_0_0_0
            || mem_addr !== 16'h0000 || dut.sp_q !== 16'hF000) begin
            errors++;
            $display("FAIL rst_mid_outputs: ctrl=%b addr=%h sp=%h required 0001000/0000/F000",
                     {stall, win_op, xfer_we_L, mem_req, mem_we, err}, mem_addr, dut.sp_q);
        end
        @(negedge clock);
        reset_L = 1'b1;
        mem_ack = 1'b0;
        @(negedge clock);
        checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0 || win_op !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_after: stall=%b req=%b win_op=%b required 0/0/00", stall, mem_req, win_op);
        end
    endtask

    initial begin
        test_reset();
        test_push3();
        test_spill();
        test_spill_slow_ack();
        test_fill();
        test_errors();
        test_reset_mid_spill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
